updi_block_writer: RTL and testbench

Consumes one decoded program block (length, address, type, data bytes) from `program_decoder` and turns it into the UPDI byte sequence that writes the block into target memory. The sequence is a pointer store, a REPEAT, then a pointer-increment store burst. Bytes go out on a valid/ready stream to the UPDI UART transmitter. The block sits between `program_decoder` and the UPDI PHY. Its start/ready/done handshake mirrors the decoder's, so a top-level sequencer can alternate the two blocks.

---
 rtl/updi_block_writer_if.sv | 13 +
 rtl/updi_block_writer.sv | 223 ++++++++++++++++++++++
 tb/tb_updi_block_writer.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/updi_block_writer_if.sv
// Byte stream to the UPDI UART transmitter plus the received-byte strobe from the target.
interface updi_block_writer_if;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;
   logic [7:0] rx_data;
   logic       rx_valid;

   modport master (output tx_data, output tx_valid, input tx_ready,
                   input rx_data, input rx_valid);
   modport slave  (input tx_data, input tx_valid, output tx_ready,
                   output rx_data, output rx_valid);
endinterface

// File: rtl/updi_block_writer.sv
// Turns one decoded program block into the UPDI ST ptr / REPEAT / ST *ptr++ byte sequence.
// Optional macro UPDI_BLOCK_WRITER_ACK_EN: wait for target ACK after the address and after each data byte.
module updi_block_writer #(
   parameter int          DATA_BLOCK_MAX_SIZE  = 64,
   parameter int          DATA_BLOCK_ADDR_BITS = $clog2(DATA_BLOCK_MAX_SIZE),
   parameter logic [15:0] FLASH_BASE           = 16'h8000,
   parameter int          ACK_TIMEOUT          = 4096
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic                                 start,
   output logic                                 ready,
   output logic                                 done,
   output logic                                 error,
   output logic                                 eof,
   input  logic [7:0]                           block_length,
   input  logic [15:0]                          block_address,
   input  logic [7:0]                           block_type,
   input  logic [DATA_BLOCK_MAX_SIZE-1:0][7:0]  block_data,
   updi_block_writer_if.master                  phy
);

   typedef enum logic [2:0] {
      IDLE,
      HDR,
      DATA,
`ifdef UPDI_BLOCK_WRITER_ACK_EN
      ACK_WAIT,
`endif
      FINISH
   } state_t;

   state_t      state, state_n;
   logic [7:0]  cnt, cnt_n, len, len_n;
   logic [15:0] addr, addr_n;
   logic [7:0]  tx_data_q, tx_data_n;
   logic        tx_valid_q, tx_valid_n;
   logic        ready_q, ready_n, done_q, done_n, error_q, error_n, eof_q, eof_n;
   logic        accept, last_data;
   logic [7:0]  cnt_inc;

`ifdef UPDI_BLOCK_WRITER_ACK_EN
   localparam int TW = $clog2(ACK_TIMEOUT + 1);
   logic [TW-1:0] timer, timer_n;
   logic          ack_hdr, ack_hdr_n;
`else
   wire unused_rx = ^{phy.rx_data, phy.rx_valid};
   localparam int unused_ack_timeout = ACK_TIMEOUT;
`endif

   // Header: ST ptr (16-bit addr), REPEAT length-1, ST *ptr++ opcode.
   function automatic logic [7:0] hdr_byte(input logic [3:0] i, input logic [15:0] a,
                                           input logic [7:0] l);
      case (i)
         4'd0, 4'd4, 4'd7: hdr_byte = 8'h55;
         4'd1:             hdr_byte = 8'h69;
         4'd2:             hdr_byte = a[7:0];
         4'd3:             hdr_byte = a[15:8];
         4'd5:             hdr_byte = 8'hA0;
         4'd6:             hdr_byte = l - 8'd1;
         default:          hdr_byte = 8'h64;
      endcase
   endfunction

   assign accept    = tx_valid_q && phy.tx_ready;
   assign cnt_inc   = cnt + 8'd1;
   assign last_data = (cnt == len - 8'd1);

   always_comb begin
      state_n    = state;
      cnt_n      = cnt;
      len_n      = len;
      addr_n     = addr;
      tx_data_n  = tx_data_q;
      tx_valid_n = tx_valid_q;
      ready_n    = ready_q;
      done_n     = 1'b0;
      error_n    = error_q;
      eof_n      = eof_q;
`ifdef UPDI_BLOCK_WRITER_ACK_EN
      timer_n    = timer;
      ack_hdr_n  = ack_hdr;
`endif
      case (state)
         IDLE: begin
            ready_n = 1'b1;
            if (start && ready_q) begin
               len_n   = block_length;
               addr_n  = block_address + FLASH_BASE;
               cnt_n   = 8'd0;
               ready_n = 1'b0;
               error_n = 1'b0;
               eof_n   = (block_type == 8'h01);
               if (block_type == 8'h00 && block_length != 8'd0 &&
                   int'({24'd0, block_length}) <= DATA_BLOCK_MAX_SIZE) begin
                  state_n    = HDR;
                  tx_data_n  = 8'h55;
                  tx_valid_n = 1'b1;
               end else begin
                  state_n = FINISH;
                  error_n = (block_type == 8'h00) &&
                            (int'({24'd0, block_length}) > DATA_BLOCK_MAX_SIZE);
               end
            end
         end
         HDR: begin
            if (accept) begin
`ifdef UPDI_BLOCK_WRITER_ACK_EN
               if (cnt == 8'd3) begin
                  tx_valid_n = 1'b0;
                  ack_hdr_n  = 1'b1;
                  timer_n    = '0;
                  state_n    = ACK_WAIT;
               end else
`endif
               if (cnt == 8'd8) begin
                  state_n   = DATA;
                  cnt_n     = 8'd0;
                  tx_data_n = block_data[0];
               end else begin
                  cnt_n     = cnt_inc;
                  tx_data_n = hdr_byte(cnt_inc[3:0], addr, len);
               end
            end
         end
         DATA: begin
            if (accept) begin
`ifdef UPDI_BLOCK_WRITER_ACK_EN
               tx_valid_n = 1'b0;
               ack_hdr_n  = 1'b0;
               timer_n    = '0;
               state_n    = ACK_WAIT;
`else
               // Last byte finishes directly so done lands one cycle after it.
               if (last_data) begin
                  tx_valid_n = 1'b0;
                  done_n     = 1'b1;
                  ready_n    = 1'b1;
                  state_n    = IDLE;
               end else begin
                  cnt_n     = cnt_inc;
                  tx_data_n = block_data[cnt_inc[DATA_BLOCK_ADDR_BITS-1:0]];
               end
`endif
            end
         end
`ifdef UPDI_BLOCK_WRITER_ACK_EN
         ACK_WAIT: begin
            timer_n = timer + 1'b1;
            if (phy.rx_valid) begin
               if (phy.rx_data != 8'h40) begin
                  error_n = 1'b1;
                  state_n = FINISH;
               end else if (ack_hdr) begin
                  state_n    = HDR;
                  cnt_n      = cnt_inc;
                  tx_data_n  = hdr_byte(cnt_inc[3:0], addr, len);
                  tx_valid_n = 1'b1;
               end else if (last_data) begin
                  state_n = FINISH;
               end else begin
                  state_n    = DATA;
                  cnt_n      = cnt_inc;
                  tx_data_n  = block_data[cnt_inc[DATA_BLOCK_ADDR_BITS-1:0]];
                  tx_valid_n = 1'b1;
               end
            end else if (timer == TW'(ACK_TIMEOUT - 1)) begin
               error_n = 1'b1;
               state_n = FINISH;
            end
         end
`endif
         FINISH: begin
            done_n  = 1'b1;
            ready_n = 1'b1;
            state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         cnt        <= 8'd0;
         len        <= 8'd0;
         addr       <= 16'd0;
         tx_data_q  <= 8'h00;
         tx_valid_q <= 1'b0;
         ready_q    <= 1'b0;
         done_q     <= 1'b0;
         error_q    <= 1'b0;
         eof_q      <= 1'b0;
`ifdef UPDI_BLOCK_WRITER_ACK_EN
         timer      <= '0;
         ack_hdr    <= 1'b0;
`endif
      end else begin
         state      <= state_n;
         cnt        <= cnt_n;
         len        <= len_n;
         addr       <= addr_n;
         tx_data_q  <= tx_data_n;
         tx_valid_q <= tx_valid_n;
         ready_q    <= ready_n;
         done_q     <= done_n;
         error_q    <= error_n;
         eof_q      <= eof_n;
`ifdef UPDI_BLOCK_WRITER_ACK_EN
         timer      <= timer_n;
         ack_hdr    <= ack_hdr_n;
`endif
      end
   end

   assign ready        = ready_q;
   assign done         = done_q;
   assign error        = error_q;
   assign eof          = eof_q;
   assign phy.tx_data  = tx_data_q;
   assign phy.tx_valid = tx_valid_q;

endmodule

// File: tb/tb_updi_block_writer.sv
// Directed and randomized blocks checked against a byte-sequence model built from the block fields.
module tb_updi_block_writer;
   localparam int MAX = 64;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              start = 1'b0;
   logic              ready, done, error, eof;
   logic [7:0]        block_length = 8'd0;
   logic [7:0]        block_type = 8'd0;
   logic [15:0]       block_address = 16'd0;
   logic [MAX-1:0][7:0] bdata;

   updi_block_writer_if phy();

   updi_block_writer #(.DATA_BLOCK_MAX_SIZE(MAX)) dut (
      .clk(clk), .rst(rst), .start(start), .ready(ready), .done(done),
      .error(error), .eof(eof), .block_length(block_length),
      .block_address(block_address), .block_type(block_type),
      .block_data(bdata), .phy(phy)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad = 0;
   logic [7:0] got_q[$];
   logic [7:0] exp_q[$];
   logic       exp_err, exp_eof;
   int         done_cyc, last_acc, stall_err, valid_seen;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // Expected UPDI bytes for a block, straight from the block fields.
   task automatic build_model(input logic [7:0] typ, input logic [7:0] len, input logic [15:0] adr);
      logic [15:0] a;
      a = adr + 16'h8000;
      exp_q.delete();
      if (typ == 8'h00 && len >= 8'd1 && int'(len) <= MAX) begin
         exp_q = '{8'h55, 8'h69, a[7:0], a[15:8], 8'h55, 8'hA0, len - 8'd1, 8'h55, 8'h64};
         for (int i = 0; i < int'(len); i++) exp_q.push_back(bdata[i]);
      end
      exp_err = (typ == 8'h00) && (int'(len) > MAX);
      exp_eof = (typ == 8'h01);
   endtask

   task automatic fill_data();
      for (int i = 0; i < MAX; i++) bdata[i] = 8'($urandom);
   endtask

   // mode 0: tx_ready high, 1: toggle 1-0, 2: random. hold_start keeps start high while busy.
   task automatic run_block(input logic [7:0] typ, input logic [7:0] len, input logic [15:0] adr,
                            input int mode, input bit hold_start);
      bit         prev_stall;
      logic [7:0] prev_dat;
      int         nchk;
      build_model(typ, len, adr);
      got_q.delete();
      done_cyc = -1; last_acc = -1; stall_err = 0; valid_seen = 0;
      prev_stall = 1'b0; prev_dat = 8'h00;
      @(negedge clk);
      block_type = typ; block_length = len; block_address = adr; start = 1'b1;
      for (int cyc = 1; cyc <= 2000; cyc++) begin
         @(negedge clk);
         if (!hold_start) start = 1'b0;
         phy.rx_valid = 1'($urandom);
         phy.rx_data  = 8'($urandom);
         if (prev_stall && (phy.tx_valid !== 1'b1 || phy.tx_data !== prev_dat)) stall_err++;
         if (phy.tx_valid === 1'b1) valid_seen++;
         if (done === 1'b1) begin
            done_cyc = cyc;
            start = 1'b0;
            break;
         end
         case (mode)
            0:       phy.tx_ready = 1'b1;
            1:       phy.tx_ready = cyc[0];
            default: phy.tx_ready = 1'($urandom);
         endcase
         if (phy.tx_valid === 1'b1 && phy.tx_ready) begin
            got_q.push_back(phy.tx_data);
            last_acc = cyc;
         end
         prev_stall = (phy.tx_valid === 1'b1) && !phy.tx_ready;
         prev_dat   = phy.tx_data;
      end
      start = 1'b0;
      check("done_seen", 32'(done_cyc != -1), 32'd1);
      check("byte_count", 32'(got_q.size()), 32'(exp_q.size()));
      nchk = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
      for (int i = 0; i < nchk; i++)
         check($sformatf("byte%0d", i), 32'(got_q[i]), 32'(exp_q[i]));
      if (exp_q.size() > 0) begin
         check("done_latency", 32'(done_cyc), 32'(last_acc + 1));
         if (mode == 0) check("no_bubbles", 32'(last_acc), 32'(exp_q.size()));
      end else begin
         check("empty_done_latency", 32'(done_cyc), 32'd2);
         check("empty_no_valid", 32'(valid_seen), 32'd0);
      end
      check("stall_hold", 32'(stall_err), 32'd0);
      check("error", 32'(error), 32'(exp_err));
      check("eof", 32'(eof), 32'(exp_eof));
      check("ready_at_done", 32'(ready), 32'd1);
      @(negedge clk);
      check("done_pulse", 32'(done), 32'd0);
      check("error_held", 32'(error), 32'(exp_err));
      check("eof_held", 32'(eof), 32'(exp_eof));
   endtask

   initial begin
      int n;
      phy.tx_ready = 1'b0;
      phy.rx_valid = 1'b0;
      phy.rx_data  = 8'h00;
      bdata = '0;

      repeat (3) @(negedge clk);
      check("rst_ready", 32'(ready), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_error", 32'(error), 32'd0);
      check("rst_eof", 32'(eof), 32'd0);
      check("rst_tx_valid", 32'(phy.tx_valid), 32'd0);
      check("rst_tx_data", 32'(phy.tx_data), 32'd0);

      // start presented while ready is still low must be ignored
      rst = 1'b0;
      block_type = 8'h00; block_length = 8'd3; block_address = 16'h0100; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("ready_after_rst", 32'(ready), 32'd1);
      check("early_start_ignored", 32'(phy.tx_valid), 32'd0);
      @(negedge clk);
      check("early_start_idle", 32'(phy.tx_valid), 32'd0);

      bdata[0] = 8'hDE; bdata[1] = 8'hAD; bdata[2] = 8'hBE;
      run_block(8'h00, 8'd3, 16'h0100, 0, 1'b0);
      run_block(8'h00, 8'd3, 16'h0100, 1, 1'b1);
      run_block(8'h01, 8'd0, 16'h0000, 0, 1'b0);
      run_block(8'h07, 8'd5, 16'h0040, 0, 1'b0);
      run_block(8'h00, 8'd0, 16'h0200, 0, 1'b0);
      run_block(8'h00, 8'd65, 16'h0000, 0, 1'b0);
      fill_data();
      run_block(8'h00, 8'd4, 16'h7FFF, 0, 1'b0);
      run_block(8'h00, 8'd64, 16'h1000, 0, 1'b0);
      run_block(8'h00, 8'd64, 16'h2000, 2, 1'b1);

      // reset in the middle of a 10-byte burst, after the 5th data byte
      fill_data();
      @(negedge clk);
      block_type = 8'h00; block_length = 8'd10; block_address = 16'h1234; start = 1'b1;
      phy.tx_ready = 1'b1;
      n = 0;
      for (int cyc = 0; cyc < 100 && n < 14; cyc++) begin
         @(negedge clk);
         start = 1'b0;
         if (phy.tx_valid === 1'b1) n++;
      end
      check("rst_setup_bytes", 32'(n), 32'd14);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("midrst_tx_valid", 32'(phy.tx_valid), 32'd0);
      check("midrst_done", 32'(done), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      check("midrst_no_done", 32'(done), 32'd0);
      @(negedge clk);
      check("midrst_ready", 32'(ready), 32'd1);
      run_block(8'h00, 8'd10, 16'h1234, 0, 1'b0);

      for (int k = 0; k < 14; k++) begin
         logic [7:0] typ, len;
         fill_data();
         case ($urandom_range(0, 5))
            0:       typ = 8'h01;
            1:       typ = 8'($urandom_range(2, 255));
            default: typ = 8'h00;
         endcase
         len = 8'($urandom_range(0, 70));
         run_block(typ, len, 16'($urandom), int'($urandom_range(0, 2)), 1'($urandom));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
